// File: rtl/sobel_window.sv
// sobel_window: 3x3 Sobel edge-magnitude stage fed by three stacked line buffers.
// The three 24-bit taps form a 3x3 window and each accepted pixel yields one
// 8-bit output pixel |Gx|+|Gy| for the window centre (x-1, y-1).
// The pipeline is three clocks deep and never stalls.
// Column and row counters flag windows that are incomplete or that straddle
// a line wrap. Those windows are forced to 0.
// Optional macro SOBEL_THRESH_EN: when defined, the magnitude is binarised
// against THRESH (255 if mag >= THRESH, else 0) instead of saturated.
module sobel_window #(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080,
  parameter int THRESH = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [23:0] row0_pix,
  input  logic [23:0] row1_pix,
  input  logic [23:0] row2_pix,
  output logic        out_valid,
  output logic [7:0]  out_pixel,
  output logic        out_border
);

  localparam int DATA_W = 8;
  localparam int GRAD_W = 11;
  localparam int MAG_W  = 12;
  localparam int COL_W  = $clog2(WIDTH);
  localparam int ROW_W  = $clog2(HEIGHT);

  // Weighted column sum a + 2*c + e, at most 1020, so it fits in 10 bits.
  function automatic logic [9:0] wsum(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] c,
                                      input logic [DATA_W-1:0] e);
    return {2'b00, a} + {1'b0, c, 1'b0} + {2'b00, e};
  endfunction

  // Absolute value of a gradient. The range is +/-1020, so 10 bits hold the result.
  function automatic logic [9:0] grad_abs(input logic signed [GRAD_W-1:0] g);
    logic signed [GRAD_W-1:0] n;
    n = -g;
    return g[GRAD_W-1] ? n[9:0] : g[9:0];
  endfunction

  // Saturate the magnitude to the 8-bit pixel range.
  function automatic logic [DATA_W-1:0] sat_mag(input logic [MAG_W-1:0] m);
    return (m > MAG_W'(255)) ? 8'hFF : m[DATA_W-1:0];
  endfunction

  // Binarise the magnitude against THRESH.
  function automatic logic [DATA_W-1:0] bin_mag(input logic [MAG_W-1:0] m);
    return (m >= MAG_W'(THRESH)) ? 8'hFF : 8'h00;
  endfunction

  // Position counters
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_last, row_last, border_d;

  assign col_last = (col_q == COL_W'(WIDTH - 1));
  assign row_last = (row_q == ROW_W'(HEIGHT - 1));
  assign border_d = (col_q < COL_W'(2)) || (row_q < ROW_W'(2));

  // Advance column/row on each accepted pixel; both wrap together at frame end.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // ---- S1: capture window and border flag ----
  logic        vld_p1_q;
  logic        border_p1_q;
  logic [23:0] row0_p1_q, row1_p1_q, row2_p1_q;

  // Valid bit of stage 1; cleared on reset so in-flight pixels are dropped.
  always_ff @(posedge clk) begin
    if (reset) vld_p1_q <= 1'b0;
    else       vld_p1_q <= in_valid;
  end

  // Window data and border flag of stage 1; qualified by vld_p1_q.
  always_ff @(posedge clk) begin
    border_p1_q <= border_d;
    row0_p1_q   <= row0_pix;
    row1_p1_q   <= row1_pix;
    row2_p1_q   <= row2_pix;
  end

  // ---- S2: gradients ----
  logic [DATA_W-1:0]        t0, t1, t2, m0, m2, b0, b1, b2;
  logic signed [GRAD_W-1:0] gx_d, gy_d;
  logic signed [GRAD_W-1:0] gx_p2_q, gy_p2_q;
  logic                     vld_p2_q, border_p2_q;

  assign t0 = row2_p1_q[7:0];
  assign t1 = row2_p1_q[15:8];
  assign t2 = row2_p1_q[23:16];
  assign m0 = row1_p1_q[7:0];
  assign m2 = row1_p1_q[23:16];
  assign b0 = row0_p1_q[7:0];
  assign b1 = row0_p1_q[15:8];
  assign b2 = row0_p1_q[23:16];

  // Horizontal and vertical Sobel kernels; the middle tap of row1 has zero weight.
  always_comb begin
    gx_d = signed'({1'b0, wsum(t0, m0, b0)}) - signed'({1'b0, wsum(t2, m2, b2)});
    gy_d = signed'({1'b0, wsum(b2, b1, b0)}) - signed'({1'b0, wsum(t2, t1, t0)});
  end

  // Valid bit of stage 2.
  always_ff @(posedge clk) begin
    if (reset) vld_p2_q <= 1'b0;
    else       vld_p2_q <= vld_p1_q;
  end

  // Gradient registers of stage 2.
  always_ff @(posedge clk) begin
    gx_p2_q     <= gx_d;
    gy_p2_q     <= gy_d;
    border_p2_q <= border_p1_q;
  end

  // ---- S3: magnitude and output ----
  logic [MAG_W-1:0]  mag_d;
  logic [DATA_W-1:0] pix_d;
  logic              vld_p3_q, border_p3_q;
  logic [DATA_W-1:0] pix_p3_q;

  // Sum of absolute gradients, then saturation or binarisation, then border forcing.
  always_comb begin
    mag_d = {2'b00, grad_abs(gx_p2_q)} + {2'b00, grad_abs(gy_p2_q)};
`ifdef SOBEL_THRESH_EN
    pix_d = bin_mag(mag_d);
`else
    pix_d = sat_mag(mag_d);
`endif
    if (border_p2_q) pix_d = '0;
  end

  // Output registers; pixel and border hold their value while no output is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p3_q    <= 1'b0;
      pix_p3_q    <= '0;
      border_p3_q <= 1'b0;
    end else begin
      vld_p3_q <= vld_p2_q;
      if (vld_p2_q) begin
        pix_p3_q    <= pix_d;
        border_p3_q <= border_p2_q;
      end
    end
  end

  assign out_valid  = vld_p3_q;
  assign out_pixel  = pix_p3_q;
  assign out_border = border_p3_q;

endmodule

// File: tb/tb_sobel_window.sv
// Directed bench for sobel_window on a small 8x6 frame.
// Every cycle, the bench compares the outputs against an expectation that was
// queued three cycles earlier. Pixel values come from hand-computed magnitudes.
module tb_sobel_window;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int TH = 128;

  localparam logic [23:0] FLAT = 24'h646464;
  localparam logic [23:0] GB   = 24'h0A0A0A;
  localparam logic [23:0] GM   = 24'h050505;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [23:0] row0_pix, row1_pix, row2_pix;
  logic        out_valid;
  logic [7:0]  out_pixel;
  logic        out_border;

  int checks = 0;
  int errors = 0;

  logic       ev [3];
  logic [7:0] ep [3];
  logic       eb [3];
  int         bc, br;
  logic [7:0] last_pix;
  logic       last_b;
  int         nv, nb;

  always #5 clk = ~clk;

  sobel_window #(.WIDTH(W), .HEIGHT(H), .THRESH(TH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .row0_pix   (row0_pix),
    .row1_pix   (row1_pix),
    .row2_pix   (row2_pix),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .out_border (out_border)
  );

  // Expected output for an interior window with the given |Gx|+|Gy|.
  function automatic logic [7:0] fpix(input int mag);
`ifdef SOBEL_THRESH_EN
    return (mag >= TH) ? 8'd255 : 8'd0;
`else
    return (mag > 255) ? 8'd255 : 8'(mag);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare the current outputs against the expectation queued three cycles ago.
  task automatic observe();
    check("out_valid", 32'(out_valid), 32'(ev[2]));
    if (ev[2]) begin
      check("out_pixel", 32'(out_pixel), 32'(ep[2]));
      check("out_border", 32'(out_border), 32'(eb[2]));
      last_pix = ep[2];
      last_b   = eb[2];
      nv++;
      if (out_border === 1'b1) nb++;
    end else begin
      check("hold_pixel", 32'(out_pixel), 32'(last_pix));
      check("hold_border", 32'(out_border), 32'(last_b));
    end
  endtask

  // One clock: check outputs, queue this input's expectation, drive inputs.
  task automatic step(input logic v, input logic [23:0] r0, input logic [23:0] r1,
                      input logic [23:0] r2, input logic [7:0] epix);
    logic bd;
    @(negedge clk);
    observe();
    ev[2] = ev[1]; ep[2] = ep[1]; eb[2] = eb[1];
    ev[1] = ev[0]; ep[1] = ep[0]; eb[1] = eb[0];
    bd = (bc < 2) || (br < 2);
    ev[0] = v;
    ep[0] = bd ? 8'd0 : epix;
    eb[0] = bd;
    if (v) begin
      if (bc == W - 1) begin
        bc = 0;
        br = (br == H - 1) ? 0 : br + 1;
      end else begin
        bc = bc + 1;
      end
    end
    reset    = 1'b0;
    in_valid = v;
    row0_pix = r0;
    row1_pix = r1;
    row2_pix = r2;
  endtask

  // Hold reset for n cycles; everything in flight is expected to vanish.
  task automatic do_reset(input int n, input bit do_obs);
    @(negedge clk);
    if (do_obs) observe();
    reset    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ev[i] = 1'b0; ep[i] = 8'd0; eb[i] = 1'b0;
    end
    bc = 0; br = 0;
    last_pix = 8'd0;
    last_b   = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0;
    row0_pix = '0; row1_pix = '0; row2_pix = '0;
    for (int i = 0; i < 3; i++) begin
      ev[i] = 1'b0; ep[i] = 8'd0; eb[i] = 1'b0;
    end
    bc = 0; br = 0; last_pix = 8'd0; last_b = 1'b0;
    do_reset(2, 1'b0);

    // Flat frame: every output 0; border where col<2 or row<2 (16 + 4*2 = 24).
    nv = 0; nb = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        step(1'b1, FLAT, FLAT, FLAT, 8'd0);

    // Next frame rows 0 and 1 (all border) after the frame wrap.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, FLAT, FLAT, FLAT, 8'd0);
      if (i == 2) begin
        check("flat_outputs", 32'(nv), 32'd48);
        check("flat_borders", 32'(nb), 32'd24);
      end
    end

    // Row 2: cols 0,1 border, then interior windows.
    step(1'b1, FLAT, FLAT, FLAT, 8'd0);
    step(1'b1, FLAT, FLAT, FLAT, 8'd0);
    step(1'b1, 24'h0080FF, 24'h0080FF, 24'h0080FF, fpix(1020)); // vertical step, Gx=1020
    step(1'b1, GB, GM, 24'h000000, fpix(40));                   // Gy=40
    // |Gx|+|Gy| is always even, so 126 is the largest magnitude below 128.
    step(1'b1, 24'h003F00, 24'h0, 24'h0, fpix(126));
    step(1'b1, 24'h004000, 24'h0, 24'h0, fpix(128));
    // Bubbles across the line wrap: 1,0,1,0,1,0,1,0,1.
    step(1'b1, 24'h008000, 24'h0, 24'h0, fpix(256));            // col 6
    step(1'b0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 8'd0);
    step(1'b1, 24'h007F00, 24'h0, 24'h0, fpix(254));            // col 7
    step(1'b0, 24'h123456, 24'h654321, 24'hABCDEF, 8'd0);
    step(1'b1, GB, GM, 24'h0, fpix(40));                        // row 3 col 0, border
    step(1'b0, 24'h0, 24'h0, 24'h0, 8'd0);
    step(1'b1, GB, GM, 24'h0, fpix(40));                        // row 3 col 1, border
    step(1'b0, 24'h0, 24'h0, 24'h0, 8'd0);
    step(1'b1, 24'h0, 24'h0, 24'hFFFFFF, fpix(1020));           // col 2, Gy=-1020
    step(1'b1, 24'h0, 24'h0, 24'h000A00, fpix(20));             // col 3, Gy=-20
    step(1'b1, 24'h0, 24'h00000A, 24'h0, fpix(20));             // col 4, Gx=20

    // Reset at row 3 col 5 with cols 3 and 4 still in flight.
    do_reset(1, 1'b1);
    step(1'b1, GB, GM, 24'h0, fpix(40));                        // treated as col 0 row 0
    step(1'b1, GB, GM, 24'h0, fpix(40));
    repeat (4) step(1'b0, 24'h0, 24'h0, 24'h0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
